// File: rtl/net_pkg.sv
// net_pkg: shared constants, FSM state type and bit-placement helper for the
// image binarizer front end and the Net classifier that consumes its output.
//   IMG_DIM  : input image side in pixels (32)
//   BLK_DIM  : side of one summed block in pixels (4)
//   GRID_DIM : side of the binary output image in blocks (8)
//   SUM_W    : block-sum width; 16*255 = 4080 fits in 12 bits
//   PIX_W    : grayscale pixel width
package net_pkg;

    localparam int IMG_DIM  = 32;
    localparam int BLK_DIM  = 4;
    localparam int GRID_DIM = 8;
    localparam int SUM_W    = 12;
    localparam int PIX_W    = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        PUBLISH = 2'd2
    } binz_state_t;

    // Position of block (row, col) in the 64-bit image word; MSB is top-left.
    function automatic logic [5:0] grid_bit(input logic [2:0] row, input logic [2:0] col);
        return 6'(63 - (8 * int'(row) + int'(col)));
    endfunction

endpackage

// File: rtl/image_binarizer_if.sv
// image_binarizer_if: pixel stream in, binary image out.
//   pix_valid/pix_ready/pix_data/pix_sof : raster-order pixel stream
//   img_out/img_valid                    : 8x8 binary image and update pulse
//   frame_err                            : pulse on a frame aborted by early sof
// Handshake: a pixel beat transfers on a rising clk edge where pix_valid and
// pix_ready are both 1. The source keeps pix_valid, pix_data and pix_sof
// stable until the beat transfers; pix_ready does not depend on pix_valid.
interface image_binarizer_if;
    import net_pkg::*;

    logic             pix_valid;
    logic             pix_ready;
    logic [PIX_W-1:0] pix_data;
    logic             pix_sof;
    logic [63:0]      img_out;
    logic             img_valid;
    logic             frame_err;

    modport master (
        output pix_valid, pix_data, pix_sof,
        input  pix_ready, img_out, img_valid, frame_err
    );

    modport slave (
        input  pix_valid, pix_data, pix_sof,
        output pix_ready, img_out, img_valid, frame_err
    );

endinterface

// File: rtl/block_row_accum.sv
// block_row_accum: eight 12-bit block-sum accumulators for the current block
// row, plus the threshold compare that produces one bit per block.
//   clk, rst_n : clock, synchronous active-low reset
//   add_en     : add pix into accumulator col_blk
//   restart    : clear all accumulators and load pix into col_blk (new frame)
//   clear      : clear all accumulators (block row closed this beat)
//   col_blk    : block column 0..7 of the current pixel
//   pix        : pixel value
//   hit[k]     : (acc[k] + this beat) >= THRESH, column k
module block_row_accum
    import net_pkg::*;
#(
    parameter int THRESH = 2048
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             add_en,
    input  logic             restart,
    input  logic             clear,
    input  logic [2:0]       col_blk,
    input  logic [PIX_W-1:0] pix,
    output logic [7:0]       hit
);

    logic [SUM_W-1:0] acc      [GRID_DIM];
    logic [SUM_W-1:0] acc_next [GRID_DIM];

    // The compare sees the sum including the current beat, so the closing
    // beat of a block row contributes to its own row's result.
    always_comb begin
        for (int k = 0; k < GRID_DIM; k++) begin
            acc_next[k] = acc[k];
            if (add_en && (col_blk == 3'(k))) begin
                acc_next[k] = acc[k] + SUM_W'(pix);
            end
            hit[k] = (acc_next[k] >= SUM_W'(THRESH));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < GRID_DIM; k++) acc[k] <= '0;
        end else if (restart) begin
            for (int k = 0; k < GRID_DIM; k++) begin
                acc[k] <= (col_blk == 3'(k)) ? SUM_W'(pix) : '0;
            end
        end else if (clear) begin
            for (int k = 0; k < GRID_DIM; k++) acc[k] <= '0;
        end else if (add_en) begin
            for (int k = 0; k < GRID_DIM; k++) acc[k] <= acc_next[k];
        end
    end

endmodule

// File: rtl/image_binarizer.sv
// image_binarizer: sums each 4x4 block of a 32x32 8-bit raster frame,
// thresholds the sums and publishes the 8x8 result as a 64-bit word.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : pixel stream in, image/valid/frame_err out (slave side)
//   dbg_state  : current FSM state, for observation only
module image_binarizer
    import net_pkg::*;
#(
    parameter int THRESH = 2048
) (
    input  logic                    clk,
    input  logic                    rst_n,
    image_binarizer_if.slave        bus,
    output binz_state_t             dbg_state
);

    binz_state_t state;
    logic [4:0]  row;        // position of the next expected beat
    logic [4:0]  col;
    logic [63:0] shadow;
    logic [63:0] shadow_merged;
    logic [63:0] img_q;
    logic        img_valid_q;
    logic        frame_err_q;

    logic        accept;
    logic        start;
    logic        add_en;
    logic        row_close;
    logic        frame_end;
    logic [2:0]  col_blk;
    logic [7:0]  hit;

    assign bus.pix_ready = rst_n && (state != PUBLISH);
    assign accept        = bus.pix_valid && bus.pix_ready;
    // Any accepted sof starts a frame at (0,0), whether from IDLE or as an
    // early sof that aborts the frame in progress.
    assign start         = accept && bus.pix_sof;
    assign add_en        = accept && !bus.pix_sof && (state == ACCUM);
    assign row_close     = add_en && (col == 5'd31) && (row[1:0] == 2'd3);
    assign frame_end     = row_close && (row == 5'd31);
    assign col_blk       = start ? 3'd0 : col[4:2];

    block_row_accum #(
        .THRESH (THRESH)
    ) u_accum (
        .clk     (clk),
        .rst_n   (rst_n),
        .add_en  (add_en),
        .restart (start),
        .clear   (row_close),
        .col_blk (col_blk),
        .pix     (bus.pix_data),
        .hit     (hit)
    );

    // Shadow image with the current block row's compare bits dropped in;
    // used both for row close and for the final publish of row 7.
    always_comb begin
        shadow_merged = shadow;
        for (int k = 0; k < GRID_DIM; k++) begin
            shadow_merged[grid_bit(row[4:2], 3'(k))] = hit[k];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            row         <= '0;
            col         <= '0;
            shadow      <= '0;
            img_q       <= '0;
            img_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            img_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= ACCUM;
                        row    <= '0;
                        col    <= 5'd1;
                        shadow <= '0;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        if (bus.pix_sof) begin
                            frame_err_q <= !((row == 5'd0) && (col == 5'd0));
                            shadow      <= '0;
                            row         <= '0;
                            col         <= 5'd1;
                        end else begin
                            col <= col + 5'd1;
                            if (col == 5'd31) row <= row + 5'd1;
                            if (row_close) shadow <= shadow_merged;
                            if (frame_end) begin
                                img_q       <= shadow_merged;
                                img_valid_q <= 1'b1;
                                state       <= PUBLISH;
                            end
                        end
                    end
                end
                PUBLISH: begin
                    state <= IDLE;
                    row   <= '0;
                    col   <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.img_out   = img_q;
    assign bus.img_valid = img_valid_q;
    assign bus.frame_err = frame_err_q;
    assign dbg_state     = state;

endmodule

// File: tb/tb_image_binarizer.sv
module tb_image_binarizer;
    import net_pkg::*;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    binz_state_t dbg_state;
    int          cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    image_binarizer_if bus();

    image_binarizer #(
        .THRESH (2048)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  frame [1024];
    logic [63:0] exp_q [$];
    logic [63:0] last_img = '0;
    logic [63:0] last_dut = '0;
    logic [63:0] exp_word;
    int          valid_seen = 0;
    int          frames_exp = 0;
    int          err_seen = 0;
    int          exp_err = 0;
    int          last_acc_cyc = -100;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    task automatic checki(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // Reference: per-block sums straight from the frame array.
    function automatic logic [63:0] model_img();
        logic [63:0] img;
        int          sum;
        img = '0;
        for (int br = 0; br < 8; br++) begin
            for (int bc = 0; bc < 8; bc++) begin
                sum = 0;
                for (int dr = 0; dr < 4; dr++)
                    for (int dc = 0; dc < 4; dc++)
                        sum += int'(frame[(4 * br + dr) * 32 + 4 * bc + dc]);
                if (sum >= 2048) img[63 - (8 * br + bc)] = 1'b1;
            end
        end
        return img;
    endfunction

    // ---------------- frame builders ----------------
    task automatic fill_const(input logic [7:0] v);
        for (int i = 0; i < 1024; i++) frame[i] = v;
    endtask

    task automatic fill_random(input int lo, input int hi);
        for (int i = 0; i < 1024; i++) frame[i] = 8'($urandom_range(lo, hi));
    endtask

    task automatic fill_glyph();
        logic [7:0] glyph [8];
        glyph = '{8'h00, 8'h18, 8'h24, 8'h24, 8'h24, 8'h24, 8'h18, 8'h00};
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++)
                frame[r * 32 + c] = glyph[r / 4][7 - c / 4] ? 8'd255 : 8'd0;
    endtask

    // ---------------- driver ----------------
    task automatic beat(input logic [7:0] d, input logic sof, input int max_gap);
        logic rdy;
        int   waited;
        if (max_gap > 0 && $urandom_range(0, 2) == 0) begin
            bus.pix_valid = 1'b0;
            repeat ($urandom_range(1, max_gap)) @(posedge clk);
            #1;
        end
        bus.pix_valid = 1'b1;
        bus.pix_data  = d;
        bus.pix_sof   = sof;
        waited = 0;
        while (1) begin
            @(negedge clk);
            rdy = bus.pix_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            waited++;
            if (waited > 20) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: waited %0d cycles, required <= 20", waited);
                break;
            end
        end
        last_acc_cyc  = cyc;
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
    endtask

    task automatic send_frame(input int nbeats, input int max_gap);
        for (int i = 0; i < nbeats; i++) beat(frame[i], (i == 0), max_gap);
        if (nbeats == 1024) begin
            exp_q.push_back(model_img());
            frames_exp++;
        end
    endtask

    task automatic idle(input int n);
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            check64("ready_in_reset", 64'(bus.pix_ready), 64'd0);
        end else begin
            if (bus.img_valid) begin
                valid_seen++;
                check64("ready_low_publish", 64'(bus.pix_ready), 64'd0);
                checki("publish_latency", cyc - last_acc_cyc + 1, 1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_img_valid: got img %h, expected no update", bus.img_out);
                end else begin
                    exp_word = exp_q.pop_front();
                    check64("img_out", bus.img_out, exp_word);
                    last_img = exp_word;
                end
                last_dut = bus.img_out;
            end else begin
                check64("img_out_hold", bus.img_out, last_img);
                check64("ready_high", 64'(bus.pix_ready), 64'd1);
            end
            if (bus.frame_err) begin
                err_seen++;
                checki("frame_err_latency", cyc - last_acc_cyc + 1, 1);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bus.pix_valid = 1'b0;
        bus.pix_data  = '0;
        bus.pix_sof   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        @(negedge clk);
        check64("reset_img_out", bus.img_out, 64'd0);
        check64("reset_img_valid", 64'(bus.img_valid), 64'd0);
        check64("reset_frame_err", 64'(bus.frame_err), 64'd0);
        checki("reset_state", int'(dbg_state), int'(IDLE));
        @(posedge clk);
        #1;

        // All-zero frame
        fill_const(8'd0);
        check64("model_zero", model_img(), 64'h0);
        send_frame(1024, 0);
        idle(3);
        checki("zero_valid_count", valid_seen, 1);
        check64("zero_img", last_dut, 64'h0);

        // All-255 frame
        fill_const(8'd255);
        check64("model_ones", model_img(), 64'hFFFF_FFFF_FFFF_FFFF);
        send_frame(1024, 0);
        idle(3);
        check64("ones_img", last_dut, 64'hFFFF_FFFF_FFFF_FFFF);

        // "0" glyph
        fill_glyph();
        check64("model_glyph", model_img(), 64'h0018_2424_2424_1800);
        send_frame(1024, 0);
        idle(3);
        check64("glyph_img", last_dut, 64'h0018_2424_2424_1800);

        // Threshold boundary: block (0,0) sum 2048 then 2047
        fill_const(8'd0);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                frame[r * 32 + c] = (r < 2) ? 8'd255 : 8'd1;
        check64("model_thresh_eq", model_img(), 64'h8000_0000_0000_0000);
        send_frame(1024, 0);
        idle(3);
        check64("thresh_2048", last_dut, 64'h8000_0000_0000_0000);
        frame[3 * 32 + 3] = 8'd0;
        send_frame(1024, 0);
        idle(3);
        check64("thresh_2047", last_dut, 64'h0);

        // Early sof after 500 beats, then full all-255 frame
        fill_random(0, 255);
        send_frame(500, 0);
        fill_const(8'd255);
        exp_err++;
        send_frame(1024, 0);
        idle(3);
        checki("early_sof_err", err_seen, exp_err);
        check64("early_sof_img", last_dut, 64'hFFFF_FFFF_FFFF_FFFF);
        checki("early_sof_valid_count", valid_seen, frames_exp);

        // sof on beat (31,31) counts as early
        fill_random(0, 255);
        send_frame(1023, 0);
        fill_glyph();
        exp_err++;
        send_frame(1024, 0);
        idle(3);
        checki("sof_at_last_err", err_seen, exp_err);
        check64("sof_at_last_img", last_dut, 64'h0018_2424_2424_1800);

        // Random frames with random valid gaps; glyph with gaps too
        for (int f = 0; f < 4; f++) begin
            fill_random(96, 160);
            send_frame(1024, (f == 0) ? 0 : 3);
            idle($urandom_range(0, 3));
        end
        fill_glyph();
        send_frame(1024, 3);
        idle(3);
        check64("gap_glyph_img", last_dut, 64'h0018_2424_2424_1800);

        // Reset mid-frame, non-sof beats in IDLE dropped
        fill_random(0, 255);
        send_frame(300, 0);
        rst_n = 1'b0;
        exp_q.delete();
        last_img = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);
        check64("post_reset_img", bus.img_out, 64'h0);
        checki("post_reset_state", int'(dbg_state), int'(IDLE));
        for (int i = 0; i < 10; i++) beat(8'd255, 1'b0, 0);
        idle(3);
        checki("idle_drop_valid_count", valid_seen, frames_exp);
        checki("idle_drop_state", int'(dbg_state), int'(IDLE));
        fill_random(96, 160);
        send_frame(1024, 2);
        idle(3);

        checki("final_queue_empty", exp_q.size(), 0);
        checki("final_valid_count", valid_seen, frames_exp);
        checki("final_err_count", err_seen, exp_err);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/image_binarizer.md
# image_binarizer

Front-end stage feeding the `Net` classifier. It accepts a raster-order 32x32 8-bit grayscale pixel stream and sums each non-overlapping 4x4 block. Each block sum is compared against a threshold, producing one bit per block. The block publishes the resulting 8x8 binary image as the 64-bit word `Net.in` consumes.

## Interface
Parameters:
- `THRESH`, default 2048: block-sum threshold; bit = 1 when sum >= THRESH (12-bit compare).

Ports:
- `clk`: input, 1 bit. Single clock.
- `rst_n`: input, 1 bit. Reset, synchronous, active-low.
- `pix_valid`: input, 1 bit. Pixel beat valid.
- `pix_ready`: output, 1 bit. Stage can accept a beat.
- `pix_data`: input, 8 bits. Grayscale pixel, 0 = black.
- `pix_sof`: input, 1 bit. Marks the beat as pixel (0,0) of a frame.
- `img_out`: output, 64 bits. Binary image to `Net.in`. Bit 63-(8*R+C) is block row R, block column C (MSB = top-left).
- `img_valid`: output, 1 bit. One-cycle pulse when `img_out` is updated.
- `frame_err`: output, 1 bit. One-cycle pulse when a frame is aborted by an early `pix_sof`.

## Operation
- Beat accepted when `pix_valid && pix_ready`.
- States:
  - IDLE: `pix_ready`=1. Beats without `pix_sof` are discarded. A beat with `pix_sof` is treated as (0,0), accumulated, and moves the block to ACCUM.
  - ACCUM: `pix_ready`=1. Counters row r (0..31) and col c (0..31) advance in raster order per accepted beat. The pixel is added to `acc[c>>2]` (eight 12-bit accumulators).
  - PUBLISH: `pix_ready`=0 for exactly one cycle. `img_out` is loaded from the shadow image and `img_valid`=1. Next state is IDLE.
- Block-row close on the accepted beat with c==31 and r%4==3:
  - Compare `acc_next[k] >= THRESH` for k=0..7, where `acc_next` includes the current beat.
  - Write the 8 result bits into shadow row r>>2 and clear all accumulators.
- Frame end: beat (31,31) closes block row 7 and transitions to PUBLISH.
- Arithmetic: the maximum block sum is 16*255 = 4080, which fits in 12 bits; no saturation is needed.
- Boundary conditions:
  - `pix_sof` on an accepted beat in ACCUM at any position other than (0,0): pulse `frame_err`, clear accumulators and shadow, and treat the beat as (0,0) of a new frame. State stays ACCUM.
  - `pix_sof` arriving in PUBLISH is not accepted (ready=0); the source holds it until IDLE.
  - `pix_sof` on beat (31,31) itself counts as early sof.
  - `pix_valid` gaps: counters hold, with no other effect.
  - Reset mid-frame discards the partial frame. `img_out` is cleared to 0 and the previous image is lost.
- Reset values: state IDLE, counters 0, accumulators 0, shadow 0, `img_out`=0, `img_valid`=0, `frame_err`=0. `pix_ready`=0 while `rst_n`=0, and 1 from the first cycle after reset.
- `img_out` holds its value between frames. It changes only in the PUBLISH cycle or on reset.

## Timing
- All outputs are registered except `pix_ready`, which is decoded from state and `rst_n`.
- Latency: last pixel accepted at edge T. `img_out` and `img_valid` are valid in the cycle after T, `pix_ready`=0 in that cycle, and `pix_ready`=1 again the following cycle.
- Minimum frame period: 1024 accepted beats + 1 PUBLISH cycle.
- `frame_err` asserts in the cycle after the offending beat's accept edge.
- `Net` samples `img_out` on any clock edge; the word is stable for at least 1025 cycles between updates.

## Structure
- Shared package `net_pkg` holds:
  - `IMG_DIM`=32, `BLK_DIM`=4, `GRID_DIM`=8, `SUM_W`=12, `PIX_W`=8.
  - Function `grid_bit(R,C)` = 63-(8*R+C).
  - State enum `binz_state_t` {IDLE, ACCUM, PUBLISH}.
- One sub-module, `block_row_accum`: the eight accumulators, add-select by column block, clear, and the 8-bit threshold compare output. The top level holds the FSM, counters, shadow and output registers.

## Test plan
- All-zero frame, continuous valid: `img_out`=64'h0 and `img_valid` pulses once, 1 cycle after beat 1023. `pix_ready` is low exactly that cycle.
- All-255 frame: `img_out`=64'hFFFF_FFFF_FFFF_FFFF.
- Frame painting 4x4 blocks of 255 per the 8x8 "0" glyph (others 0): `img_out`=64'h0018_2424_2424_1800.
- Threshold boundary:
  - Block (0,0) with 8 pixels 255 + 8 pixels 1 (sum 2048) -> bit 63 = 1.
  - Change one pixel to 0 (sum 2047) -> bit 63 = 0.
- Early sof: after 500 beats, send `pix_sof` with `pix_data`=255.
  - Expect: `frame_err` pulses once, then a full all-255 frame -> all-ones image and exactly one `img_valid`.
- Robustness:
  - Random `pix_valid` gaps give results identical to continuous streaming.
  - `rst_n` low mid-frame: `img_out`=0 and `img_valid` stays 0 until the next complete frame; non-sof beats in IDLE are dropped.
